wl_phase_timer: RTL

//  Sequences the timed end-of-round phases of the game FSM.

---
 rtl/heroe_pkg.sv | 28 ++
 rtl/sec_tick_gen.sv | 34 +++
 rtl/wl_phase_timer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/heroe_pkg.sv
// Shared codes for the game FSM and its timed helpers.
// State codes, round-result codes and the end-of-round phase enum.
package heroe_pkg;

    typedef enum logic [2:0] {
        OFF  = 3'd0,
        WLCM = 3'd1,
        CH   = 3'd2,
        GAME = 3'd3,
        WL   = 3'd4,
        PA   = 3'd5
    } fsm_state_t;

    localparam logic [1:0] RES_LOST = 2'b01;
    localparam logic [1:0] RES_WIN  = 2'b10;

    typedef enum logic [1:0] {
        P_IDLE,
        P_HOLD,
        P_SHOW,
        P_WAIT
    } phase_t;

    function automatic logic res_valid(input logic [1:0] r);
        return (r == RES_LOST) || (r == RES_WIN);
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Free-running prescaler giving a one-cycle tick every DIVISOR clocks.
// Shared by the timed blocks; clr restarts the second from zero.
module sec_tick_gen #(
    parameter int DIVISOR = 27_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int W = $clog2(DIVISOR);
    localparam logic [W-1:0] LAST = W'(DIVISOR - 1);

    if (DIVISOR < 2) begin : g_bad_div
        $error("sec_tick_gen: DIVISOR must be >= 2");
    end

    logic [W-1:0] r_cnt;

    assign tick = run && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= tick ? '0 : r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/wl_phase_timer.sv
// Times the GAME->WL hold and WL->PA display phases in whole seconds.
// Define WLT_COUNTDOWN_EN to make sec_cnt show seconds remaining.
module wl_phase_timer
    import heroe_pkg::*;
#(
    parameter int DIVISOR = 27_000_000,
    parameter int HOLD_S  = 3,
    parameter int SHOW_S  = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] state,
    input  logic [1:0] w_or_l,
    output logic       go_wl,
    output logic       go_pa,
    output logic       busy,
    output logic [3:0] sec_cnt
);

    if (DIVISOR < 2) begin : g_bad_div
        $error("wl_phase_timer: DIVISOR must be >= 2");
    end
    if (HOLD_S < 1 || HOLD_S > 15) begin : g_bad_hold
        $error("wl_phase_timer: HOLD_S must be 1..15");
    end
    if (SHOW_S < 1 || SHOW_S > 15) begin : g_bad_show
        $error("wl_phase_timer: SHOW_S must be 1..15");
    end

    localparam logic [3:0] HOLD_L = 4'(HOLD_S);
    localparam logic [3:0] SHOW_L = 4'(SHOW_S);

    phase_t     r_phase;
    phase_t     w_phase_nx;
    logic [3:0] r_sec;
    logic [3:0] w_sec_nx;
    logic       r_show;
    logic       w_show_nx;
    logic       w_tick;
    logic       w_valid;
    logic       w_in_game;
    logic       w_in_wl;

    assign w_valid   = res_valid(w_or_l);
    assign w_in_game = (state == GAME);
    assign w_in_wl   = (state == WL);
    assign busy      = (r_phase == P_HOLD) || (r_phase == P_SHOW);

    sec_tick_gen #(
        .DIVISOR (DIVISOR)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!busy),
        .run   (busy),
        .tick  (w_tick)
    );

    // Abort is tested before the tick so a dropped result never pulses.
    always_comb begin
        w_phase_nx = r_phase;
        w_sec_nx   = r_sec;
        w_show_nx  = r_show;
        go_wl      = 1'b0;
        go_pa      = 1'b0;
        unique case (r_phase)
            P_IDLE: begin
                w_sec_nx = '0;
                if (w_valid && w_in_game) begin
                    w_phase_nx = P_HOLD;
                    w_show_nx  = 1'b0;
                end else if (w_valid && w_in_wl) begin
                    w_phase_nx = P_SHOW;
                    w_show_nx  = 1'b1;
                end
            end
            P_HOLD: begin
                if (!w_valid || !w_in_game) begin
                    w_phase_nx = P_IDLE;
                end else if (w_tick) begin
                    w_sec_nx = r_sec + 4'd1;
                    if (w_sec_nx == HOLD_L) begin
                        go_wl      = 1'b1;
                        w_phase_nx = P_WAIT;
                    end
                end
            end
            P_SHOW: begin
                if (!w_valid || !w_in_wl) begin
                    w_phase_nx = P_IDLE;
                end else if (w_tick) begin
                    w_sec_nx = r_sec + 4'd1;
                    if (w_sec_nx == SHOW_L) begin
                        go_pa      = 1'b1;
                        w_phase_nx = P_WAIT;
                    end
                end
            end
            P_WAIT: begin
                if (!w_valid || (r_show ? !w_in_wl : !w_in_game)) begin
                    w_phase_nx = P_IDLE;
                end
            end
            default: w_phase_nx = P_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= P_IDLE;
            r_sec   <= '0;
            r_show  <= 1'b0;
        end else begin
            r_phase <= w_phase_nx;
            r_sec   <= w_sec_nx;
            r_show  <= w_show_nx;
        end
    end

`ifdef WLT_COUNTDOWN_EN
    logic [3:0] w_lim;
    assign w_lim   = r_show ? SHOW_L : HOLD_L;
    assign sec_cnt = busy ? (w_lim - r_sec) : 4'd0;
`else
    assign sec_cnt = (r_phase == P_IDLE) ? 4'd0 : r_sec;
`endif

endmodule
